// File: rtl/addsub_sched_pkg.sv
// Shared constants and helpers for the add/sub round-robin scheduler.
// NREQ requesters, op encodings, and datapath width derivation.
package addsub_sched_pkg;

    localparam int NREQ = 2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Datapath width: operand size plus two guard bits.
    function automatic int width(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational signed W-bit adder/subtractor (wraps, no saturation).
// Ports: i_a, i_b operands; i_sel 0=add 1=sub; o_sum result; o_ovf (ADDSUB_OVF_EN).
module addsub_core
    import addsub_sched_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sel,
`ifdef ADDSUB_OVF_EN
    output logic         o_ovf,
`endif
    output logic [W-1:0] o_sum
);

    always_comb begin
        if (i_sel == OP_SUB) o_sum = i_a - i_b;
        else                 o_sum = i_a + i_b;
    end

`ifdef ADDSUB_OVF_EN
    logic w_sign_cond;

    // Add overflows on equal operand signs, sub on differing ones;
    // in both cases the result sign must disagree with a.
    always_comb begin
        if (i_sel == OP_SUB) w_sign_cond = i_a[W-1] ^ i_b[W-1];
        else                 w_sign_cond = ~(i_a[W-1] ^ i_b[W-1]);
        o_ovf = w_sign_cond & (o_sum[W-1] ^ i_a[W-1]);
    end
`endif

endmodule

// File: rtl/addsub_rr_scheduler.sv
// Round-robin share of one signed add/sub unit between two requesters,
// with a single registered result stage and valid/ready on every side.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_a/req_b/
// req_sel per requester (W-bit lanes packed i*W); res_valid/res_ready,
// res_sum, res_id; res_ovf only when macro ADDSUB_OVF_EN is defined.
module addsub_rr_scheduler
    import addsub_sched_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = width(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_sel,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
`ifdef ADDSUB_OVF_EN
    output logic              res_ovf,
`endif
    output logic              res_id
);

    logic            r_ptr;
    logic            r_valid;
    logic            r_id;
    logic [W-1:0]    r_sum;

    logic [NREQ-1:0] w_grant;
    logic            w_can;
    logic            w_fire;
    logic            w_idx;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_sel;
    logic [W-1:0]    w_sum;

    // Slot is free if empty or being drained this cycle.
    assign w_can = ~r_valid | res_ready;

    always_comb begin
        w_grant = '0;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
            default: w_grant = 2'b00;
        endcase
    end

    assign req_ready = w_grant & {NREQ{w_can & rst_n}};
    assign w_fire    = |(req_valid & req_ready);
    assign w_idx     = w_grant[1];

    assign w_a   = w_idx ? req_a[2*W-1:W] : req_a[W-1:0];
    assign w_b   = w_idx ? req_b[2*W-1:W] : req_b[W-1:0];
    assign w_sel = w_idx ? req_sel[1]     : req_sel[0];

`ifdef ADDSUB_OVF_EN
    logic w_ovf;
    logic r_ovf;

    addsub_core #(.W(W)) u_core (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_sel (w_sel),
        .o_ovf (w_ovf),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)      r_ovf <= 1'b0;
        else if (w_fire) r_ovf <= w_ovf;
    end

    assign res_ovf = r_ovf;
`else
    addsub_core #(.W(W)) u_core (
        .i_a   (w_a),
        .i_b   (w_b),
        .i_sel (w_sel),
        .o_sum (w_sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_valid <= 1'b0;
            r_id    <= 1'b0;
            r_sum   <= '0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
            r_id    <= w_idx;
            r_sum   <= w_sum;
            r_ptr   <= ~w_idx;
        end else if (res_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign res_valid = r_valid;
    assign res_sum   = r_sum;
    assign res_id    = r_id;

endmodule
